// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-wide RAM port between instruction fetch and the MEM stage,
// sequencing little-endian byte runs. Define MEM_ARB_RR_EN for round-robin arbitration.
module mem_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic [31:0]       if_data,
    output logic              if_done,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_size,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_done,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_wr,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din
);
    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_MEM} owner_t;

    state_t            state_q, state_d;
    owner_t            owner_q, owner_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [2:0]        nbytes_q, nbytes_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] ram_a_q, ram_a_d;
    logic              we_q, we_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       data_q, data_d;
    logic [31:0]       if_data_q, if_data_d;
    logic [31:0]       mem_rdata_q, mem_rdata_d;
    logic              ram_wr_q, ram_wr_d;
    logic [7:0]        ram_dout_q, ram_dout_d;
    logic              if_done_q, if_done_d;
    logic              mem_done_q, mem_done_d;

    logic              if_want;
    logic              grant_mem;
    logic              grant_if;
    logic              finish;
    logic [2:0]        nxt;
    logic [1:0]        cap_lane;
    logic [1:0]        wr_lane;
    logic [31:0]       data_cap;

    assign if_want = if_req && !if_flush;

`ifdef MEM_ARB_RR_EN
    // Remembers whether MEM won the most recent grant; reset favours MEM.
    logic last_mem_q;

    always_comb begin
        grant_mem = mem_req && !(if_want && last_mem_q);
        grant_if  = if_want && !grant_mem;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_mem_q <= 1'b0;
        end else if (rdy && state_q == IDLE && (grant_mem || grant_if)) begin
            last_mem_q <= grant_mem;
        end
    end
`else
    assign grant_mem = mem_req;
    assign grant_if  = if_want && !mem_req;
`endif

    // Cycle j of XFER presents address j (if j < N) and, for loads, captures byte j-1.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        nbytes_d    = nbytes_q;
        base_d      = base_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        data_d      = data_q;
        ram_a_d     = ram_a_q;
        ram_wr_d    = ram_wr_q;
        ram_dout_d  = ram_dout_q;
        if_data_d   = if_data_q;
        mem_rdata_d = mem_rdata_q;
        if_done_d   = 1'b0;
        mem_done_d  = 1'b0;
        finish      = 1'b0;
        nxt         = cnt_q + 3'd1;
        cap_lane    = 2'(cnt_q - 3'd1);
        wr_lane     = nxt[1:0];
        data_cap    = data_q | (32'(ram_din) << {cap_lane, 3'b000});

        case (state_q)
            IDLE: begin
                ram_a_d     = '0;
                ram_wr_d    = 1'b0;
                ram_dout_d  = 8'h00;
                if_data_d   = 32'h0;
                mem_rdata_d = 32'h0;
                owner_d     = OWN_NONE;
                if (grant_mem) begin
                    owner_d = OWN_MEM;
                    base_d  = mem_addr;
                    we_d    = mem_we;
                    wdata_d = mem_wdata;
                    case (mem_size)
                        2'd0:    nbytes_d = 3'd1;
                        2'd1:    nbytes_d = 3'd2;
                        default: nbytes_d = 3'd4;
                    endcase
                end else if (grant_if) begin
                    owner_d  = OWN_IF;
                    base_d   = if_addr;
                    we_d     = 1'b0;
                    wdata_d  = 32'h0;
                    nbytes_d = 3'd4;
                end
                if (grant_mem || grant_if) begin
                    state_d    = XFER;
                    cnt_d      = 3'd0;
                    data_d     = 32'h0;
                    ram_a_d    = base_d;
                    ram_wr_d   = we_d;
                    ram_dout_d = we_d ? wdata_d[7:0] : 8'h00;
                end
            end
            XFER: begin
                cnt_d      = nxt;
                ram_a_d    = '0;
                ram_wr_d   = 1'b0;
                ram_dout_d = 8'h00;
                if (owner_q == OWN_IF && if_flush) begin
                    state_d = IDLE;
                    owner_d = OWN_NONE;
                end else if (we_q) begin
                    if (nxt == nbytes_q) begin
                        finish = 1'b1;
                    end else begin
                        ram_a_d    = base_q + ADDR_W'(nxt);
                        ram_wr_d   = 1'b1;
                        ram_dout_d = 8'(wdata_q >> {wr_lane, 3'b000});
                    end
                end else begin
                    if (cnt_q != 3'd0) begin
                        data_d = data_cap;
                    end
                    if (cnt_q == nbytes_q) begin
                        finish = 1'b1;
                    end else if (nxt < nbytes_q) begin
                        ram_a_d = base_q + ADDR_W'(nxt);
                    end
                end
            end
            DONE: begin
                state_d     = IDLE;
                owner_d     = OWN_NONE;
                ram_a_d     = '0;
                ram_wr_d    = 1'b0;
                ram_dout_d  = 8'h00;
                if_data_d   = 32'h0;
                mem_rdata_d = 32'h0;
            end
            default: begin
                state_d = IDLE;
                owner_d = OWN_NONE;
            end
        endcase

        if (finish) begin
            state_d = DONE;
            if (owner_q == OWN_IF) begin
                if_done_d = 1'b1;
                if_data_d = data_d;
            end else begin
                mem_done_d  = 1'b1;
                mem_rdata_d = data_d;
            end
        end
    end

    // rdy low freezes every register; reset wins regardless of rdy.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= OWN_NONE;
            cnt_q       <= 3'd0;
            nbytes_q    <= 3'd0;
            base_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= 32'h0;
            data_q      <= 32'h0;
            ram_a_q     <= '0;
            ram_wr_q    <= 1'b0;
            ram_dout_q  <= 8'h00;
            if_data_q   <= 32'h0;
            mem_rdata_q <= 32'h0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
        end else if (rdy) begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            nbytes_q    <= nbytes_d;
            base_q      <= base_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            data_q      <= data_d;
            ram_a_q     <= ram_a_d;
            ram_wr_q    <= ram_wr_d;
            ram_dout_q  <= ram_dout_d;
            if_data_q   <= if_data_d;
            mem_rdata_q <= mem_rdata_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
        end
    end

    // A held write strobe is masked while stalled so the byte lands once when rdy returns.
    assign ram_a     = ram_a_q;
    assign ram_wr    = ram_wr_q && rdy;
    assign ram_dout  = ram_dout_q;
    assign if_data   = if_data_q;
    assign if_done   = if_done_q && !if_flush;
    assign mem_rdata = mem_rdata_q;
    assign mem_done  = mem_done_q;
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single byte-wide RAM port between instruction fetch (IF) and the data-memory stage (MEM, loads/stores addressed by EX). Grants one requester at a time and sequences each access as a run of single-byte RAM cycles, little-endian. Assembles read data into 32-bit words and signals completion with a one-cycle done pulse. Sits between the IF/MEM pipeline stages and the top-level RAM interface.

## Interface
- `ADDR_W`, default 32: address width for requester and RAM addresses.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `rdy` in 1: global enable; low freezes all state.
- `if_req` in 1: IF read request, level, held until `if_done`.
- `if_addr` in ADDR_W: fetch address; always a word read.
- `if_flush` in 1: abort any pending or in-flight IF access.
- `if_data` out 32: fetched word, valid only while `if_done`=1.
- `if_done` out 1: one-cycle completion pulse for IF.
- `mem_req` in 1: MEM request, level, held until `mem_done`.
- `mem_we` in 1: 1=store, 0=load.
- `mem_size` in 2: 0=byte, 1=half, 2/3=word.
- `mem_addr` in ADDR_W: byte address.
- `mem_wdata` in 32: store data, low bytes used.
- `mem_rdata` out 32: load data, zero-extended, valid only while `mem_done`=1.
- `mem_done` out 1: one-cycle completion pulse for MEM.
- `ram_a` out ADDR_W: RAM byte address.
- `ram_wr` out 1: RAM write strobe.
- `ram_dout` out 8: RAM write byte.
- `ram_din` in 8: RAM read byte; reflects the address presented in the previous cycle.

## Operation
- Reset values: `ram_a`=0, `ram_wr`=0, `ram_dout`=0, `if_data`=0, `mem_rdata`=0, `if_done`=0, `mem_done`=0, state IDLE, owner none, byte counter 0.
- FSM states:
  - IDLE: sample requests. Grant a requester, latch its address/size/we/wdata, clear the counter, go to XFER.
  - XFER: issue one byte per cycle at `ram_a`=base+i.
    - Loads: capture `ram_din` one cycle after each address. Go to DONE after the last capture.
    - Stores: drive `ram_wr`=1 and `ram_dout`=wdata[8i+7:8i]. Go to DONE after the last write.
  - DONE: pulse the owner's done signal with the assembled data, then return to IDLE.
- Byte count N: 1, 2 or 4 per `mem_size`; IF is always 4. Byte i goes to bits [8i+7:8i].
- Addresses computed modulo 2^ADDR_W; base+i wraps past all-ones.
- Priority: MEM over IF when both requests are high in IDLE. A granted transaction is never preempted.
- `ram_a`=0 and `ram_wr`=0 in IDLE and DONE.
- Requests high during DONE are ignored; they are re-arbitrated in the next IDLE.
- `if_flush` handling:
  - In IDLE: suppresses the IF grant that cycle.
  - During an IF XFER: return to IDLE next cycle, no `if_done`.
  - During DONE for IF: `if_done` is suppressed.
  - Never affects a MEM transaction.
- `rdy`=0: state, counter, latched request and all outputs hold, except that `ram_wr` is forced to 0. A byte write in progress resumes when `rdy` returns.
- `rst` mid-transaction: abort immediately to reset values. No done pulse.

## Timing
- Request sampled in IDLE at cycle T; first RAM address at T+1.
- Load or IF of N bytes: addresses T+1..T+N, captures T+2..T+N+1, done at T+N+2.
  - Word: done at T+6.
  - Half: done at T+4.
  - Byte: done at T+3.
- Store of N bytes: `ram_wr` high T+1..T+N, done at T+N+1. Word store: done at T+5.
- Back-to-back: next grant earliest one cycle after done.
- A word fetch followed immediately by a word fetch gives a 7-cycle spacing between `if_done` pulses.

## Configuration
- `MEM_ARB_RR_EN` defined:
  - Round-robin arbitration.
  - When both requests are high in IDLE, the grant goes to the requester that was not granted most recently.
  - After reset, MEM has priority.
- `MEM_ARB_RR_EN` undefined: fixed priority, MEM always wins.

## Test plan
- Word load: `mem_req`=1, `mem_addr`=0x100, RAM bytes 11,22,33,44. Required: `ram_a` 0x100..0x103 on T+1..T+4; `mem_done` at T+6 with `mem_rdata`=0x44332211.
- Half store: `mem_size`=1, `mem_addr`=0x2FFF, `mem_wdata`=0xDEADBEEF. Required: `ram_wr` at T+1 (0x2FFF, EF) and T+2 (0x3000, BE); `mem_done` at T+3.
- Both requests high in IDLE, fixed priority: MEM granted first; IF granted in the IDLE after `mem_done`; `if_done` 7 cycles after `mem_done`.
- `if_flush` at T+3 of a fetch: no `if_done`; state is IDLE at T+4; a pending `mem_req` is granted at T+4.
- `rdy` low during T+2..T+4 of a word store: `ram_wr`=0 and `ram_a` frozen while low; all 4 bytes still written exactly once; done 3 cycles later than the T+5 baseline.
- `rst` at T+2 of a word load: all outputs 0 next cycle, no `mem_done`; a new request after reset is serviced normally.
